nibble_deframer: RTL
====================

# nibble_deframer

Downstream consumer of the 4-bit serial-in shift register. Each cycle it watches the register's parallel window for a 4-bit sync nibble. Once it finds one, it slices the following serial stream into nibbles and assembles them into payload words. Words are handed to the next stage over a valid/ready handshake, with frame-lock, sync-error and overrun status.

## Interface
- SYNC, 4'b1011, sync nibble value (first-received bit in bit 3)
- N_NIB, 2, payload nibbles per frame (1..8); word width W = 4*N_NIB
- MAX_MISS, 2, consecutive sync misses while locked before returning to hunt (1..7)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- sr_i  in  4  shift-register window; sr_i[0] = newest bit, sr_i[3] = oldest; advances by one bit every cycle
- data_ready_i  in  1  downstream accepts data_o on an edge where data_valid_o=1
- data_o  out  W  assembled payload word; first-received nibble in bits [W-1:W-4]
- data_valid_o  out  1  data_o holds an unaccepted word
- locked_o  out  1  frame lock established
- sync_err_o  out  1  one-cycle pulse: expected sync nibble mismatched
- overrun_o  out  1  sticky: a word was dropped because the output was occupied; cleared only by reset

## Operation
- State machine: HUNT, PAYLOAD, SYNC_CHECK. Internal counters:
  - phase, 2 bits
  - nib_cnt, 0..N_NIB-1
  - miss_cnt, 0..MAX_MISS
- Nibble boundary: phase==3. phase is cleared when a sync is accepted and increments (mod 4) every cycle outside HUNT.
- HUNT: compare sr_i to SYNC every cycle.
  - On match: go to PAYLOAD, phase<=0, nib_cnt<=0.
  - locked_o stays 0.
- PAYLOAD: at each boundary, shift sr_i into the assembly register (first nibble lands in the MSBs) and increment nib_cnt.
  - On the N_NIB-th nibble: issue the word to the output stage and go to SYNC_CHECK.
- SYNC_CHECK: at the boundary, compare sr_i to SYNC.
  - Match: locked_o<=1, miss_cnt<=0, go to PAYLOAD.
  - Mismatch while unlocked: sync_err_o pulse, go to HUNT.
  - Mismatch while locked: sync_err_o pulse, miss_cnt++.
    - If miss_cnt reaches MAX_MISS: go to HUNT, locked_o<=0, miss_cnt<=0.
    - Otherwise (flywheel): go to PAYLOAD, keeping nibble alignment.
- Words are emitted in every PAYLOAD pass, locked or not.
- Output stage, one-word register:
  - Empty: the new word loads and data_valid_o<=1.
  - Full with data_ready_i=1 on the same edge: the new word replaces the old one and data_valid_o stays 1.
  - Full with data_ready_i=0: the new word is dropped, data_o is unchanged, overrun_o<=1.
  - Accept with no new word: data_valid_o<=0; data_o keeps its old value.
- data_o is stable while data_valid_o=1 and not accepted.
- sr_i is ignored while reset=1.
- Reset values:
  - data_o=0, data_valid_o=0, locked_o=0, sync_err_o=0, overrun_o=0
  - state=HUNT, all counters 0

## Timing
- Sync match is seen in cycle n (sr_i==SYNC). Payload nibble k (k=0..N_NIB-1) is then sampled in cycle n+4(k+1).
- data_valid_o rises in cycle n+4*N_NIB+1 (one-cycle registered latency after the last sample).
- The sync check is sampled in cycle n+4(N_NIB+1). sync_err_o is high in the following cycle only.
- Frame period: 4*(N_NIB+1) cycles. The next frame's first payload nibble is sampled 4 cycles after the sync check.
- Match in HUNT: PAYLOAD from the next cycle; no extra alignment cycle.
- Reset asserted mid-frame: all outputs reach their reset values at the first edge with reset=1.
  - The first possible sync match is the first cycle after reset deasserts.
  - A partially assembled word is discarded.
- Upstream bit latency: a bit on x_i in cycle t appears in sr_i[0] in cycle t+1, so the last payload bit at t gives data_valid_o at t+2.

## Test plan
- Lock and decode:
  - Stimulus: bits 1011 0101 1100 1011 0101 1100 with data_ready_i=1.
  - Required: data_o=8'h5C with data_valid_o for 1 cycle, 9 cycles after the first sync's last bit enters sr_i; locked_o=1 after the second sync; sync_err_o never pulses.
- Backpressure:
  - Stimulus: locked stream with payloads 8'hA3 then 8'h4E; data_ready_i=0 throughout.
  - Required: data_o holds 8'hA3 and data_valid_o=1; overrun_o goes 1 when 8'h4E completes.
- Accept-and-load on the same edge:
  - Stimulus: ready asserted exactly on the completion edge of the second word.
  - Required: data_o becomes the second word, data_valid_o stays 1, overrun_o=0.
- Flywheel and lock loss (MAX_MISS=2, locked):
  - Stimulus: corrupt one sync to 4'b0000, then two consecutive syncs.
  - Required:
    - Single miss: one sync_err_o pulse, locked_o stays 1, the next word decodes correctly.
    - Two consecutive misses: two pulses, then locked_o=0 and the block is back in HUNT.
- Unlocked false sync:
  - Stimulus: 1011 followed by a non-sync nibble at the check position.
  - Required: sync_err_o pulse, HUNT, locked_o remains 0.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle during the second payload nibble.
  - Required: all outputs 0 at that edge, overrun_o cleared; relock and decode correctly afterwards.

Source files
------------

// File: rtl/nibble_deframer.sv
// Frame deframer fed by a 4-bit serial-in shift register window. It hunts for a sync
// nibble, then slices payload nibbles into words and holds them in a one-word output register.
module nibble_deframer #(
    parameter logic [3:0] SYNC     = 4'b1011,
    parameter int         N_NIB    = 2,
    parameter int         MAX_MISS = 2,
    localparam int        W        = 4 * N_NIB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   sr_i,
    input  logic         data_ready_i,
    output logic [W-1:0] data_o,
    output logic         data_valid_o,
    output logic         locked_o,
    output logic         sync_err_o,
    output logic         overrun_o
);
    localparam int NCW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam int MCW = $clog2(MAX_MISS + 1);
    localparam logic [NCW-1:0] NIB_LAST  = NCW'(N_NIB - 1);
    localparam logic [MCW-1:0] MISS_LAST = MCW'(MAX_MISS - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        SYNC_CHECK
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     phase_q, phase_d;
    logic [NCW-1:0] nib_cnt_q, nib_cnt_d;
    logic [MCW-1:0] miss_cnt_q, miss_cnt_d;
    logic [W-1:0]   asm_q, asm_d;
    logic           locked_q, locked_d;
    logic           sync_err_q, sync_err_d;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;

    logic           boundary;
    logic           sync_hit;
    logic           word_stb;
    logic [W-1:0]   nib_shift;

    assign boundary  = (phase_q == 2'd3);
    assign sync_hit  = (sr_i == SYNC);
    // The oldest nibble falls off the top, so the first-received nibble ends in the MSBs.
    assign nib_shift = (asm_q << 4) | W'(sr_i);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        nib_cnt_d  = nib_cnt_q;
        miss_cnt_d = miss_cnt_q;
        asm_d      = asm_q;
        locked_d   = locked_q;
        sync_err_d = 1'b0;
        word_stb   = 1'b0;

        if (state_q != HUNT) begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            HUNT: begin
                if (sync_hit) begin
                    state_d   = PAYLOAD;
                    phase_d   = 2'd0;
                    nib_cnt_d = '0;
                    asm_d     = '0;
                end
            end
            PAYLOAD: begin
                if (boundary) begin
                    asm_d = nib_shift;
                    if (nib_cnt_q == NIB_LAST) begin
                        word_stb  = 1'b1;
                        nib_cnt_d = '0;
                        state_d   = SYNC_CHECK;
                    end else begin
                        nib_cnt_d = nib_cnt_q + NCW'(1);
                    end
                end
            end
            SYNC_CHECK: begin
                if (boundary) begin
                    if (sync_hit) begin
                        locked_d   = 1'b1;
                        miss_cnt_d = '0;
                        state_d    = PAYLOAD;
                    end else begin
                        sync_err_d = 1'b1;
                        if (!locked_q) begin
                            state_d = HUNT;
                        end else if (miss_cnt_q == MISS_LAST) begin
                            state_d    = HUNT;
                            locked_d   = 1'b0;
                            miss_cnt_d = '0;
                        end else begin
                            // Flywheel: phase keeps running, so nibble alignment is preserved.
                            miss_cnt_d = miss_cnt_q + MCW'(1);
                            state_d    = PAYLOAD;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (word_stb) begin
            if (!valid_q || data_ready_i) begin
                data_d  = nib_shift;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            phase_q    <= 2'd0;
            nib_cnt_q  <= '0;
            miss_cnt_q <= '0;
            asm_q      <= '0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            nib_cnt_q  <= nib_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            asm_q      <= asm_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign locked_o     = locked_q;
    assign sync_err_o   = sync_err_q;
    assign overrun_o    = overrun_q;

endmodule
